// File: rtl/sum_accumulator_pkg.sv
// Shared types and default sizes for the sum accumulator.
//   state_t     : FSM states IDLE, ACCUM, DONE
//   DEF_WIDTH   : default data/sum width
//   DEF_CNT_W   : default item-count width
package sum_accumulator_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sum_accumulator_accum_reg.sv
// accum_reg: WIDTH-bit running sum with sticky carry flag.
// Optional macro SUM_ACCUMULATOR_SAT_EN: saturate at 2^WIDTH-1 instead of wrapping.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear of sum and ovf
//   en       : add data into sum this cycle
//   data     : addend
//   sum      : registered running sum
//   ovf      : registered sticky carry-out flag
module accum_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] next_sum;

  // One extra bit so the carry out is visible.
  assign wide = {1'b0, sum} + {1'b0, data};

`ifdef SUM_ACCUMULATOR_SAT_EN
  // Once pinned at all-ones, any further add carries again, so it stays pinned.
  assign next_sum = wide[WIDTH] ? {WIDTH{1'b1}} : wide[WIDTH-1:0];
`else
  assign next_sum = wide[WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      sum <= next_sum;
      ovf <= ovf | wide[WIDTH];
    end
  end

endmodule

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums len items from a valid/ready stream, then pulses done.
// Optional macro SUM_ACCUMULATOR_SAT_EN (in accum_reg): saturating instead of wrapping sum.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start,len : begin a run of len items (sampled in IDLE only)
//   in_data, in_valid, in_ready : operand stream; ready decoded from state only
//   sum, ovf  : result and sticky overflow, held in IDLE until next start
//   busy      : high in ACCUM and DONE
//   done      : one-cycle pulse when sum is final
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             clr, add_en;

  // State and remaining-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state, count and datapath controls.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    clr        = 1'b0;
    add_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clr = 1'b1;
          if (len == '0) begin
            state_next = DONE;
          end else begin
            cnt_next   = len;
            state_next = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          add_en   = 1'b1;
          cnt_next = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake and status come straight off the state register.
  assign in_ready = (state == ACCUM);
  assign busy     = (state == ACCUM) || (state == DONE);
  assign done     = (state == DONE);

  accum_reg #(
    .WIDTH(WIDTH)
  ) u_accum_reg (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (add_en),
    .data(in_data),
    .sum (sum),
    .ovf (ovf)
  );

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator (WIDTH=8, CNT_W=4).
// Driver pushes {sum, ovf, done cycle} per run; a negedge monitor pops on done.
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] sum;
  logic       ovf;
  logic       busy;
  logic       done;

  typedef struct {
    logic [7:0] sum;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sum_accumulator #(.WIDTH(8), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .len     (len),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sum     (sum),
    .ovf     (ovf),
    .busy    (busy),
    .done    (done)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding run.
  always @(negedge clk) begin
    if (done) begin
      check("done_single_cycle", int'(prev_done), 0);
      check("busy_in_done", int'(busy), 1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sum", int'(sum), int'(e.sum));
        check("ovf", int'(ovf), int'(e.ovf));
        check("done_cycle", cyc, e.cyc);
      end
    end
    prev_done = done;
  end

  // Issue start; lat = edges after the start edge until done is visible.
  task automatic start_run(input logic [3:0] l, input logic [7:0] es,
                           input logic eo, input int lat);
    exp_t e;
    start = 1'b1;
    len   = l;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.sum = es;
    e.ovf = eo;
    e.cyc = cyc + lat;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] d);
    check("in_ready_before_send", int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout actual=busy required=idle");
    end
  endtask

  task automatic check_quiet(input string tag, input logic [7:0] es, input logic eo);
    @(negedge clk);
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_sum"}, int'(sum), int'(es));
    check({tag, "_ovf"}, int'(ovf), int'(eo));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_data = '0; in_valid = 1'b0;
    idle(2);
    check_quiet("reset", 8'd0, 1'b0);
    rst = 1'b0;
    idle(1);

    // 10+20+30, no stalls: done 3 edges after the start edge.
    start_run(4'd3, 8'd60, 1'b0, 3);
    send(8'd10); send(8'd20); send(8'd30);
    wait_idle();
    idle(3);
    check_quiet("hold_after_run", 8'd60, 1'b0);

    // Stall of 4 cycles mid-run.
    start_run(4'd2, 8'd12, 1'b0, 6);
    send(8'd5);
    idle(4);
    send(8'd7);
    wait_idle();

    // Zero items: done visible right after the start edge.
    start_run(4'd0, 8'd0, 1'b0, 0);
    wait_idle();

    // Overflow: 200+100.
`ifdef SUM_ACCUMULATOR_SAT_EN
    start_run(4'd2, 8'd255, 1'b1, 2);
`else
    start_run(4'd2, 8'd44, 1'b1, 2);
`endif
    send(8'd200); send(8'd100);
    wait_idle();
    check_quiet("hold_ovf", sum, 1'b1);

    // ovf sticks after the overflowing add; later adds keep saturation.
`ifdef SUM_ACCUMULATOR_SAT_EN
    start_run(4'd3, 8'd255, 1'b1, 3);
`else
    start_run(4'd3, 8'd49, 1'b1, 3);
`endif
    send(8'd200); send(8'd100); send(8'd5);
    wait_idle();

    // New start clears ovf; exact fit 255 is not an overflow.
    start_run(4'd2, 8'd255, 1'b0, 2);
    send(8'd250); send(8'd5);
    wait_idle();

    // Reset mid-run abandons it: no expectation pushed for the partial run.
    start = 1'b1; len = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    send(8'd10);
    rst = 1'b1;
    idle(1);
    check_quiet("mid_reset", 8'd0, 1'b0);
    rst = 1'b0;
    idle(2);
    start_run(4'd1, 8'd9, 1'b0, 1);
    send(8'd9);
    wait_idle();

    // start during ACCUM is ignored; original len=3 run finishes.
    start_run(4'd3, 8'd6, 1'b0, 3);
    send(8'd1);
    start = 1'b1; len = 4'd1;
    send(8'd2);
    start = 1'b0;
    send(8'd3);
    wait_idle();

    // Reset and start in the same cycle: reset wins.
    rst = 1'b1; start = 1'b1; len = 4'd2;
    idle(1);
    rst = 1'b0; start = 1'b0;
    check_quiet("rst_over_start", 8'd0, 1'b0);

    idle(3);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
